// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter and its baud clock generator
// between N_REQ byte producers; the baud select only changes while the transmitter is idle.
module uart_tx_scheduler #(
    parameter int N_REQ         = 4,
    parameter int DATA_W        = 8,
    parameter int SETTLE_CYCLES = 16,
    parameter int BUSY_TIMEOUT  = 25000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    input  logic [N_REQ*2-1:0]         req_baud,
    output logic [N_REQ-1:0]           req_ack,
    input  logic                       tx_busy,
    output logic                       tx_start,
    output logic [DATA_W-1:0]          tx_data,
    output logic [1:0]                 select,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       timeout_err
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int SUM_W = ID_W + 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic [1:0]          select_q, select_d;
    logic                tx_start_q, tx_start_d;
    logic [N_REQ-1:0]    req_ack_q, req_ack_d;
    logic                timeout_err_q, timeout_err_d;
    logic [SET_W-1:0]    set_cnt_q, set_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                busy_meta_q, busy_sync_q;

    logic                pick_found;
    logic [ID_W-1:0]     pick_idx;
    logic [ID_W-1:0]     cand;
    logic [SUM_W-1:0]    sum;
    logic [1:0]          pick_baud;

    // First valid requester at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        sum        = '0;
        cand       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, ptr_q} + SUM_W'(i);
            if (sum >= SUM_W'(N_REQ)) begin
                sum = sum - SUM_W'(N_REQ);
            end
            cand = sum[ID_W-1:0];
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
        pick_baud = req_baud[2*pick_idx +: 2];
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_id_d    = grant_id_q;
        tx_data_d     = tx_data_q;
        select_d      = select_q;
        tx_start_d    = 1'b0;
        req_ack_d     = '0;
        timeout_err_d = timeout_err_q;
        set_cnt_d     = set_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_id_d = pick_idx;
                    tx_data_d  = req_data[pick_idx*DATA_W +: DATA_W];
                    if (pick_baud != select_q) begin
                        select_d  = pick_baud;
                        set_cnt_d = '0;
                        state_d   = S_SETTLE;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_SETTLE: begin
                if (set_cnt_q >= SET_W'(SETTLE_CYCLES - 1)) begin
                    state_d = S_START;
                end else begin
                    set_cnt_d = set_cnt_q + 1'b1;
                end
            end
            S_START: begin
                tx_start_d = 1'b1;
                tmo_cnt_d  = '0;
                state_d    = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (busy_sync_q) begin
                    req_ack_d[grant_id_q] = 1'b1;
                    ptr_d   = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
                    state_d = S_WAIT_DONE;
                end else if (tmo_cnt_q >= TMO_W'(BUSY_TIMEOUT - 1)) begin
                    // Pointer left alone so the same requester is retried.
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!busy_sync_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            grant_id_q    <= '0;
            tx_data_q     <= '0;
            select_q      <= 2'b00;
            tx_start_q    <= 1'b0;
            req_ack_q     <= '0;
            timeout_err_q <= 1'b0;
            set_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
            busy_meta_q   <= 1'b0;
            busy_sync_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_id_q    <= grant_id_d;
            tx_data_q     <= tx_data_d;
            select_q      <= select_d;
            tx_start_q    <= tx_start_d;
            req_ack_q     <= req_ack_d;
            timeout_err_q <= timeout_err_d;
            set_cnt_q     <= set_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            busy_meta_q   <= tx_busy;
            busy_sync_q   <= busy_meta_q;
        end
    end

    assign req_ack     = req_ack_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign select      = select_q;
    assign grant_id    = grant_id_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: latency, settle, round-robin order,
// busy timeout with retry, mid-frame reset and late req_valid drop.
module tb_uart_tx_scheduler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [7:0]  req_baud;
    logic [3:0]  req_ack;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [1:0]  select;
    logic [1:0]  grant_id;
    logic        timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .N_REQ(4), .DATA_W(8), .SETTLE_CYCLES(16), .BUSY_TIMEOUT(25000)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_baud(req_baud),
        .req_ack(req_ack), .tx_busy(tx_busy), .tx_start(tx_start),
        .tx_data(tx_data), .select(select), .grant_id(grant_id),
        .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        tx_busy   = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_start(input string tag, input int max, output int cycles);
        logic found;
        found  = 1'b0;
        cycles = 0;
        while (cycles < max && !found) begin
            tick();
            cycles++;
            if (tx_start) found = 1'b1;
        end
        check({tag, "_start_seen"}, found, 1);
    endtask

    task automatic wait_ack(input string tag, input int max, output logic [3:0] ack, output int cycles);
        ack    = '0;
        cycles = 0;
        while (cycles < max && ack == 4'b0) begin
            tick();
            cycles++;
            ack = req_ack;
        end
        check({tag, "_ack_seen"}, (ack != 4'b0), 1);
    endtask

    task automatic serve(input string tag, input int exp_id);
        int         c;
        logic [3:0] ack;
        wait_start(tag, 60, c);
        check({tag, "_grant"}, grant_id, exp_id);
        tx_busy = 1'b1;
        wait_ack(tag, 10, ack, c);
        check({tag, "_ack"}, ack, 32'(4'b0001 << exp_id));
        tx_busy = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         c;
        int         ack_cnt;
        logic       ack_seen;
        logic [3:0] ack;
        int         exp_order[4];

        req_data = 32'h5A_C3_3C_A5;
        req_baud = 8'h00;
        tx_busy  = 1'b0;
        req_valid = '0;

        // Reset values while reset is held
        rst_n = 1'b0;
        #3;
        check("rst_tx_start", tx_start, 0);
        check("rst_ack", req_ack, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_select", select, 0);
        check("rst_grant", grant_id, 0);
        check("rst_timeout", timeout_err, 0);
        do_reset();

        // 1: single requester, matching baud, no settle
        req_valid = 4'b0001;
        wait_start("t1", 10, c);
        check("t1_latency", c, 2);
        check("t1_tx_data", tx_data, 8'hA5);
        check("t1_grant", grant_id, 0);
        check("t1_select", select, 0);
        tick();
        check("t1_start_pulse", tx_start, 0);
        tx_busy = 1'b1;
        wait_ack("t1", 10, ack, c);
        check("t1_ack", ack, 4'b0001);
        check("t1_ack_lat", c, 3);
        req_valid = '0;
        tick();
        check("t1_ack_pulse", req_ack, 0);
        tx_busy = 1'b0;
        repeat (6) tick();

        // 2: baud mismatch inserts settle
        do_reset();
        req_baud  = 8'b0011_0000;
        req_valid = 4'b0100;
        tick();
        check("t2_select_grant", select, 2'b11);
        check("t2_grant", grant_id, 2);
        wait_start("t2", 40, c);
        check("t2_latency", c, 17);
        check("t2_tx_data", tx_data, 8'hC3);
        tx_busy = 1'b1;
        wait_ack("t2", 10, ack, c);
        check("t2_ack", ack, 4'b0100);
        check("t2_select_busy", select, 2'b11);
        req_valid = '0;
        tx_busy   = 1'b0;
        repeat (6) tick();
        check("t2_select_after", select, 2'b11);

        // 3: round-robin order
        do_reset();
        req_baud  = 8'h00;
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) serve("t3a", i);
        req_valid = 4'b1001;
        exp_order = '{0, 3, 0, 3};
        for (int i = 0; i < 4; i++) serve("t3b", exp_order[i]);
        req_valid = '0;
        repeat (6) tick();

        // 4: busy timeout then retry
        do_reset();
        req_valid = 4'b0100;
        wait_start("t4", 10, c);
        check("t4_grant", grant_id, 2);
        c        = 0;
        ack_seen = 1'b0;
        while (c < 30000 && !timeout_err) begin
            tick();
            c++;
            if (req_ack != 4'b0) ack_seen = 1'b1;
        end
        check("t4_timeout_cycles", c, 25000);
        check("t4_timeout_err", timeout_err, 1);
        check("t4_no_ack", ack_seen, 0);
        wait_start("t4_retry", 10, c);
        check("t4_retry_lat", c, 2);
        check("t4_retry_grant", grant_id, 2);
        tx_busy = 1'b1;
        wait_ack("t4_retry", 10, ack, c);
        check("t4_retry_ack", ack, 4'b0100);
        check("t4_sticky", timeout_err, 1);
        req_valid = '0;
        tx_busy   = 1'b0;
        repeat (6) tick();

        // 5: async reset during WAIT_DONE
        do_reset();
        req_baud  = 8'b0000_0100;
        req_valid = 4'b0010;
        wait_start("t5", 40, c);
        tx_busy = 1'b1;
        wait_ack("t5", 10, ack, c);
        check("t5_ack", ack, 4'b0010);
        req_valid = 4'b1010;
        tick();
        rst_n   = 1'b0;
        tx_busy = 1'b0;
        #1;
        check("t5_rst_start", tx_start, 0);
        check("t5_rst_ack", req_ack, 0);
        check("t5_rst_data", tx_data, 0);
        check("t5_rst_select", select, 0);
        check("t5_rst_grant", grant_id, 0);
        tick();
        rst_n = 1'b1;
        serve("t5_resume", 1);
        req_valid = '0;
        repeat (6) tick();

        // 6: req_valid dropped during settle
        do_reset();
        req_baud  = 8'b0000_1000;
        req_valid = 4'b0010;
        tick();
        check("t6_select", select, 2'b10);
        repeat (3) tick();
        req_valid = '0;
        wait_start("t6", 40, c);
        check("t6_grant", grant_id, 1);
        tx_busy = 1'b1;
        ack_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (req_ack[1]) ack_cnt++;
            if (i == 10) tx_busy = 1'b0;
        end
        check("t6_ack_count", ack_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
